// File: rtl/vend_change_dispenser_pkg.sv
// Shared definitions for the vending change dispenser: coin codes, coin values
// in nickels, the legal credit ceiling and the dispenser state encoding.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_e;

    localparam logic [2:0] VAL_NICKEL  = 3'd1;
    localparam logic [2:0] VAL_DIME    = 3'd2;
    localparam logic [2:0] VAL_QUARTER = 3'd5;

    localparam int MAX_CREDIT = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_GAP,
        ST_FINISH
    } disp_state_e;

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Per-coin valid/ack handshake between the change dispenser (master) and the
// coin hopper (slave).
interface vend_change_dispenser_if;
    logic [1:0] DISP_COIN;
    logic       DISP_VALID;
    logic       DISP_ACK;

    modport master (output DISP_COIN, output DISP_VALID, input DISP_ACK);
    modport slave  (input DISP_COIN, input DISP_VALID, output DISP_ACK);
endinterface

// File: rtl/vend_change_dispenser_coin_select.sv
// Greedy coin choice for a remaining amount in nickels: quarter, then dime,
// then nickel; nothing when the remainder is zero.
module change_coin_select
    import vend_pkg::*;
(
    input  logic [3:0] rem_i,
    output coin_e      coin_o,
    output logic [2:0] value_o
);

    always_comb begin
        coin_o  = COIN_NONE;
        value_o = 3'd0;
        if (rem_i >= 4'd5) begin
            coin_o  = COIN_QUARTER;
            value_o = VAL_QUARTER;
        end else if (rem_i >= 4'd2) begin
            coin_o  = COIN_DIME;
            value_o = VAL_DIME;
        end else if (rem_i != 4'd0) begin
            coin_o  = COIN_NICKEL;
            value_o = VAL_NICKEL;
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Pays a refund credit out to the coin hopper one coin at a time, with a
// per-coin ack timeout that raises a sticky FAULT and abandons the payout.
module vend_change_dispenser #(
    parameter int MAX_CREDIT  = 12,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [3:0]              CREDIT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [2:0]              COIN_COUNT,
    output logic                    ERR,
    output logic                    FAULT,
    vend_change_dispenser_if.master disp
);
    import vend_pkg::*;

    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    disp_state_e      state_q;
    logic [3:0]       rem_q;
    logic [3:0]       rem_d;
    logic [2:0]       coin_count_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             fault_q;
    logic [1:0]       coin_q;
    logic             valid_q;

    coin_e            sel_coin;
    logic [2:0]       sel_value;

    change_coin_select u_sel (
        .rem_i   (rem_q),
        .coin_o  (sel_coin),
        .value_o (sel_value)
    );

    // rem_q is unchanged while a coin is outstanding, so sel_value still
    // matches the coin being acknowledged.
    assign rem_d    = rem_q - {1'b0, sel_value};
    assign to_cnt_d = to_cnt_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            rem_q        <= 4'd0;
            coin_count_q <= 3'd0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            fault_q      <= 1'b0;
            coin_q       <= COIN_NONE;
            valid_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (32'(CREDIT) > MAX_CREDIT) begin
                            err_q <= 1'b1;
                        end else begin
                            rem_q        <= CREDIT;
                            coin_count_q <= 3'd0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    if (rem_q == 4'd0) begin
                        state_q <= ST_FINISH;
                    end else begin
                        coin_q   <= sel_coin;
                        valid_q  <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (disp.DISP_ACK) begin
                        rem_q        <= rem_d;
                        coin_count_q <= coin_count_q + 3'd1;
                        valid_q      <= 1'b0;
                        coin_q       <= COIN_NONE;
                        gap_cnt_q    <= '0;
                        state_q      <= ST_GAP;
                    end else if (to_cnt_d == TO_W'(ACK_TIMEOUT)) begin
                        valid_q <= 1'b0;
                        coin_q  <= COIN_NONE;
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= ST_SELECT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign COIN_COUNT      = coin_count_q;
    assign ERR             = err_q;
    assign FAULT           = fault_q;
    assign disp.DISP_COIN  = coin_q;
    assign disp.DISP_VALID = valid_q;

endmodule
